// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin shared bit-serial adder, LSB-first, one bit per cycle
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake; ready is the one-cycle grant in IDLE
//   a0,b0,cin0         requester 0 operands
//   a1,b1,cin1         requester 1 operands
//   res_valid/ready    result handshake toward the consumer
//   res_id,sum,cout    owner of the result, a+b+cin mod 2^WIDTH, carry out
//   busy               high while an operation is running or waiting to be taken
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [0:WIDTH-1] a0,
    input  logic [0:WIDTH-1] b0,
    input  logic             cin0,
    input  logic [0:WIDTH-1] a1,
    input  logic [0:WIDTH-1] b1,
    input  logic             cin1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [0:WIDTH-1] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             rr;
    logic [CW-1:0]    cnt;
    logic [0:WIDTH-1] a_r, b_r;
    logic             carry;
    logic             win, s_bit, c_bit;

    // With [0:WIDTH-1] vectors the numerically least significant bit sits at
    // index WIDTH-1; operands shift toward it so each step reads the same index.
    always_comb begin
        win       = (req_valid == 2'b11) ? rr : req_valid[1];
        req_ready = (rst_n && state == IDLE && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
        s_bit     = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ carry;
        c_bit     = (a_r[WIDTH-1] & b_r[WIDTH-1]) | (a_r[WIDTH-1] & carry) | (b_r[WIDTH-1] & carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    a_r    <= win ? a1 : a0;
                    b_r    <= win ? b1 : b0;
                    carry  <= win ? cin1 : cin0;
                    res_id <= win;
                    cnt    <= '0;
                    sum    <= '0;
                    cout   <= 1'b0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    // New bit enters at the MSB end; after WIDTH steps the
                    // first bit computed has reached the LSB position.
                    sum   <= {s_bit, sum[0:WIDTH-2]};
                    carry <= c_bit;
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout      <= c_bit;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    rr        <= ~res_id;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: transaction-level model and per-cycle compare for serial_add_sched
module tb_serial_add_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [0:W-1] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         cin0 = 1'b0, cin1 = 1'b0;
    logic         res_valid, res_id, cout, busy;
    logic         res_ready = 1'b0;
    logic [0:W-1] sum;

    int checks = 0, passes = 0;
    int cyc = 0;
    int ops_done = 0;
    bit rand_rdy = 1'b0;

    // model state
    bit         outst = 1'b0, prev_acc = 1'b0, ptr = 1'b0;
    logic [7:0] e_sum;
    logic       e_cout, e_id;
    int         g_cyc;
    logic [7:0] last_sum;
    logic       last_cout, last_id;
    bit         grant_log[$];

    serial_add_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (rand_rdy) #1 res_ready = 1'($urandom_range(0, 1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    endtask

    function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    // Compare process: grant choice, busy, latency and result contents every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {req_ready, res_valid, res_id, sum, cout, busy}, 0);
            outst    = 1'b0;
            prev_acc = 1'b0;
            ptr      = 1'b0;
        end else begin
            logic [1:0] exp_rdy;
            logic [8:0] tot;
            bit         w;
            if (prev_acc) chk("idle_after_accept", {busy, res_valid}, 0);
            prev_acc = 1'b0;
            chk("busy", busy, outst);
            exp_rdy = outst ? 2'b00 : (req_valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req_valid;
            chk("req_ready", req_ready, exp_rdy);
            chk("res_valid", res_valid, outst && cyc >= g_cyc + W + 1);
            if (res_valid && outst) begin
                chk("sum", sum, e_sum);
                chk("cout", cout, e_cout);
                chk("res_id", res_id, e_id);
                if (res_ready) begin
                    last_sum  = sum;
                    last_cout = cout;
                    last_id   = res_id;
                    ptr       = ~e_id;
                    outst     = 1'b0;
                    prev_acc  = 1'b1;
                    ops_done++;
                end
            end else if (req_ready != 2'b00 && !outst) begin
                w     = req_ready[1];
                tot   = w ? add9(a1, b1, cin1) : add9(a0, b0, cin0);
                e_sum = tot[7:0];
                e_cout = tot[8];
                e_id  = w;
                g_cyc = cyc;
                outst = 1'b1;
                grant_log.push_back(w);
            end
        end
    end

    task automatic req(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        int n = 0;
        if (i == 0) begin a0 = a; b0 = b; cin0 = c; end
        else begin a1 = a; b1 = b; cin1 = c; end
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && n < 300) begin @(negedge clk); n++; end
        if (!req_ready[i]) chk("grant_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || res_valid) && n < 500) begin @(negedge clk); n++; end
        if (busy || res_valid) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic rand_port(input int i, input int n);
        for (int k = 0; k < n; k++)
            req(i, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("model_pin_4_2", add9(8'd4, 8'd2, 1'b0), 9'h006);
        chk("model_pin_ff_1", add9(8'hFF, 8'h01, 1'b0), 9'h100);
        chk("model_pin_7f_80_1", add9(8'h7F, 8'h80, 1'b1), 9'h100);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        res_ready = 1'b1;

        // basic add from requester 0
        req(0, 8'd4, 8'd2, 1'b0);
        wait_idle();
        chk("t1_result", {last_id, last_cout, last_sum}, {1'b0, 1'b0, 8'd6});

        // overflow cases from requester 1
        req(1, 8'd255, 8'd1, 1'b0);
        wait_idle();
        chk("t2a_result", {last_id, last_cout, last_sum}, {1'b1, 1'b1, 8'd0});
        req(1, 8'h7F, 8'h80, 1'b1);
        wait_idle();
        chk("t2b_result", {last_id, last_cout, last_sum}, {1'b1, 1'b1, 8'd0});

        // both requesters continuously valid -> alternating grants
        pulse_reset();
        grant_log.delete();
        fork
            begin req(0, 8'd1, 8'd2, 1'b0); req(0, 8'd3, 8'd4, 1'b0); end
            begin req(1, 8'd5, 8'd6, 1'b0); req(1, 8'd7, 8'd8, 1'b1); end
        join
        wait_idle();
        chk("t3_grants", grant_log.size() == 4 ? {grant_log[0], grant_log[1], grant_log[2], grant_log[3]} : 4'hF, 4'b0101);
        chk("t3_last", {last_id, last_sum}, {1'b1, 8'd16});

        // backpressure in DONE with a competing request held
        res_ready = 1'b0;
        req(0, 8'd3, 8'd5, 1'b1);
        fork
            req(1, 8'd10, 8'd20, 1'b0);
            begin
                int n = 0;
                while (!res_valid && n < 50) begin @(negedge clk); n++; end
                repeat (5) @(negedge clk);
                chk("t4_hold_valid", res_valid, 1'b1);
                chk("t4_hold_sum", sum, 8'd9);
                chk("t4_hold_req_ready", req_ready, 2'b00);
                @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        wait_idle();
        chk("t4_second", {last_id, last_cout, last_sum}, {1'b1, 1'b0, 8'd30});

        // reset in the middle of RUN
        req(0, 8'd9, 8'd9, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req_ready", req_ready, 2'b00);
        chk("t5_res_valid", res_valid, 1'b0);
        chk("t5_sum", sum, 8'd0);
        chk("t5_busy", {busy, cout, res_id}, 3'b000);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        req(1, 8'd100, 8'd27, 1'b1);
        wait_idle();
        chk("t5_after", {last_id, last_cout, last_sum}, {1'b1, 1'b0, 8'd128});

        // random traffic on both ports with random consumer backpressure
        ops_done = 0;
        rand_rdy = 1'b1;
        fork
            rand_port(0, 500);
            rand_port(1, 500);
        join
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 res_ready = 1'b1;
        wait_idle();
        chk("t6_ops", ops_done, 1000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
